// File: rtl/core_bus_pkg.sv
// rtl/core_bus_pkg.sv - shared AXI encodings and uncached fetch bridge state type
package core_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    HOLD,
    DRAIN
  } ifetch_br_state_e;

  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam int         AXI_RESP_SLVERR = 1;

  // SLVERR and DECERR both carry bit 1; EXOKAY does not.
  function automatic logic respIsError(input logic [1:0] resp);
    return resp[AXI_RESP_SLVERR];
  endfunction

endpackage

// File: rtl/inst_uncached_bridge_if.sv
// rtl/inst_uncached_bridge_if.sv - AXI4 read address / read data channel bundle
interface inst_uncached_bridge_if #(
  parameter int ID_W = 4
) ();

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/inst_uncached_bridge.sv
// rtl/inst_uncached_bridge.sv - single-word uncached instruction fetch over an AXI4 read channel
module inst_uncached_bridge
  import core_bus_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic                   clk,
  input  logic                   resetn,

  input  logic                   fetch_en,
  input  logic [31:0]            fetch_addr,
  input  logic                   fetch_accept,
  input  logic                   flush,

  output logic                   inst_valid,
  output logic [31:0]            inst_data,
  output logic                   inst_err,
  output logic                   inst_busy,

  inst_uncached_bridge_if.master axi
);

  ifetch_br_state_e state;
  ifetch_br_state_e nextState;
  logic             killQ;
  logic             killNext;
  logic             loadAddr;
  logic             loadData;
  logic             rBeat;
  logic             redirect;
  logic             unusedBits;

  assign rBeat    = axi.rvalid && axi.rlast;
  assign redirect = fetch_en && (fetch_addr != axi.araddr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      killQ <= 1'b0;
    end else begin
      state <= nextState;
      killQ <= killNext;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      axi.araddr <= '0;
    end else if (loadAddr) begin
      axi.araddr <= fetch_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_data <= '0;
      inst_err  <= 1'b0;
    end else if (loadData) begin
      inst_data <= axi.rdata;
      inst_err  <= respIsError(axi.rresp);
    end
  end

  always_comb begin
    nextState = state;
    killNext  = killQ;
    loadAddr  = 1'b0;
    loadData  = 1'b0;
    unique case (state)
      IDLE: begin
        killNext = 1'b0;
        if (fetch_en && !flush) begin
          loadAddr  = 1'b1;
          nextState = AR;
        end
      end
      // The address handshake cannot be withdrawn, so a flush here only
      // marks the eventual beat for disposal.
      AR: begin
        if (flush) begin
          killNext = 1'b1;
        end
        if (axi.arready) begin
          nextState = (killQ || flush) ? DRAIN : R;
        end
      end
      R: begin
        if (rBeat) begin
          if (flush) begin
            nextState = IDLE;
          end else begin
            loadData  = 1'b1;
            nextState = HOLD;
          end
        end else if (flush) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (rBeat) begin
          killNext  = 1'b0;
          nextState = IDLE;
        end
      end
      HOLD: begin
        if (flush || fetch_accept || redirect) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign axi.arvalid = (state == AR);
  assign axi.rready  = (state == R) || (state == DRAIN);
  assign inst_valid  = (state == HOLD);
  assign inst_busy   = (state == AR) || (state == R) || (state == DRAIN);

  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = AXI_SIZE_WORD;
  assign axi.arburst = AXI_BURST_INCR;

  // Single outstanding read with a fixed ID: the returned ID carries no information.
  assign unusedBits = ^{axi.rid, axi.rresp[0]};

endmodule

// File: tb/tb_inst_uncached_bridge.sv
// tb/tb_inst_uncached_bridge.sv - vector table and scoreboard bench for the uncached fetch bridge
module tb_inst_uncached_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        fetch_accept;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        inst_err;
  logic        inst_busy;

  inst_uncached_bridge_if #(.ID_W(4)) axi ();

  inst_uncached_bridge #(.ID_W(4), .AXI_ID(4'h0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .fetch_en     (fetch_en),
    .fetch_addr   (fetch_addr),
    .fetch_accept (fetch_accept),
    .flush        (flush),
    .inst_valid   (inst_valid),
    .inst_data    (inst_data),
    .inst_err     (inst_err),
    .inst_busy    (inst_busy),
    .axi          (axi)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } word_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          arW;
    int          rW;
    int          expLat;
    logic        expErr;
    int          holdCyc;
    bit          dropEn;
  } vec_t;

  int    vectors     = 0;
  int    miscompares = 0;
  word_t sbq[$];
  int    validRises  = 0;
  logic  prevValid   = 1'b0;
  word_t monExp;

  logic [31:0] slvData = '0;
  logic [1:0]  slvResp = '0;
  int          arWait  = 0;
  int          rWait   = 0;
  int          arSeen;
  int          rStall;
  bit          rPend;
  bit          arHs;
  bit          rHs;

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: every word the fetch stage should see is popped on the rising edge of inst_valid.
  always @(negedge clk) begin
    if (inst_valid && !prevValid) begin
      validRises++;
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got inst_data %h, required no word", inst_data);
      end else begin
        monExp = sbq.pop_front();
        check32("word_data", inst_data, monExp.data);
        check1("word_err", inst_err, monExp.err);
      end
    end
    prevValid = inst_valid;
  end

  // AXI read responder: arready after arWait cycles of arvalid, beat rWait cycles after the handshake.
  initial begin
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rid     = '0;
    arSeen = 0;
    rStall = 0;
    rPend  = 1'b0;
    forever begin
      @(negedge clk);
      arHs = axi.arvalid && axi.arready;
      rHs  = axi.rvalid && axi.rready;
      @(posedge clk);
      #1;
      if (!resetn) begin
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        rPend  = 1'b0;
        arSeen = 0;
      end else begin
        if (rHs) begin
          axi.rvalid = 1'b0;
          axi.rlast  = 1'b0;
        end
        if (arHs) begin
          rPend  = 1'b1;
          rStall = rWait;
          arSeen = 0;
        end
        if (axi.arvalid) begin
          axi.arready = (arSeen >= arWait);
          arSeen++;
        end else begin
          axi.arready = 1'b0;
          arSeen = 0;
        end
        if (rPend && !axi.rvalid) begin
          if (rStall == 0) begin
            axi.rvalid = 1'b1;
            axi.rlast  = 1'b1;
            axi.rdata  = slvData;
            axi.rresp  = slvResp;
            rPend = 1'b0;
          end else begin
            rStall--;
          end
        end
      end
    end
  end

  // endMode: 0 accept, 1 flush together with accept, 2 redirect to addr+4 while holding
  task automatic runVector(input vec_t v, input int endMode);
    int    lat;
    int    rises0;
    word_t w;
    rises0 = validRises;
    cyc();
    arWait = v.arW;
    rWait  = v.rW;
    slvData = v.data;
    slvResp = v.resp;
    fetch_en   = 1'b1;
    fetch_addr = v.addr;
    w.data = v.data;
    w.err  = v.expErr;
    sbq.push_back(w);
    sample();
    check1("idle_not_busy", inst_busy, 1'b0);
    lat = 0;
    while (!inst_valid && lat < 40) begin
      cyc();
      lat++;
      sample();
      if (lat == 1) check1("arvalid_next_cycle", axi.arvalid, 1'b1);
      if (axi.arvalid) check32("araddr_stable", axi.araddr, v.addr);
      if (!inst_valid) check1("busy_until_data", inst_busy, 1'b1);
    end
    check32("latency", 32'(lat), 32'(v.expLat));
    for (int i = 0; i < v.holdCyc; i++) begin
      cyc();
      if (v.dropEn) fetch_en = 1'b0;
      sample();
      check1("hold_valid", inst_valid, 1'b1);
      check32("hold_data", inst_data, v.data);
      check1("hold_err", inst_err, v.expErr);
    end
    if (endMode == 2) begin
      cyc();
      fetch_en   = 1'b1;
      fetch_addr = v.addr + 32'd4;
      slvData = ~v.data;
      slvResp = 2'b00;
      arWait = 0;
      rWait  = 0;
      w.data = ~v.data;
      w.err  = 1'b0;
      sbq.push_back(w);
      cyc();
      sample();
      check1("redirect_drop", inst_valid, 1'b0);
      lat = 0;
      while (!inst_valid && lat < 40) begin
        cyc();
        lat++;
        sample();
      end
      check32("redirect_latency", 32'(lat), 32'd3);
      check32("redirect_addr", axi.araddr, v.addr + 32'd4);
    end
    cyc();
    fetch_accept = 1'b1;
    if (endMode == 1) begin
      flush    = 1'b1;
      fetch_en = 1'b0;
    end
    cyc();
    fetch_accept = 1'b0;
    flush    = 1'b0;
    fetch_en = 1'b0;
    sample();
    check1("accept_drops_valid", inst_valid, 1'b0);
    check1("accept_idle", inst_busy, 1'b0);
    if (endMode == 1) begin
      check1("hold_flush_no_ar", axi.arvalid, 1'b0);
      cyc();
      sample();
      check1("hold_flush_no_ar_later", axi.arvalid, 1'b0);
    end
    check32("valid_rises", 32'(validRises), 32'(rises0 + ((endMode == 2) ? 2 : 1)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   n;
    int   rises0;
    logic hs;

    vecs[0] = '{32'hbfc00000, 32'h3c08bfc0, 2'b00, 0, 0, 3,  1'b0, 0, 1'b0};
    vecs[1] = '{32'hbfc00004, 32'h24080001, 2'b00, 5, 3, 11, 1'b0, 1, 1'b0};
    vecs[2] = '{32'hbfc00008, 32'h11112222, 2'b10, 1, 0, 4,  1'b1, 2, 1'b0};
    vecs[3] = '{32'hbfc0000c, 32'h00000000, 2'b00, 0, 2, 5,  1'b0, 1, 1'b1};
    vecs[4] = '{32'hbfc00010, 32'hffffffff, 2'b11, 2, 1, 6,  1'b1, 0, 1'b0};
    vecs[5] = '{32'h80001000, 32'ha5a5a5a5, 2'b01, 0, 0, 3,  1'b0, 3, 1'b1};

    resetn       = 1'b0;
    fetch_en     = 1'b0;
    fetch_addr   = '0;
    fetch_accept = 1'b0;
    flush        = 1'b0;
    repeat (3) cyc();
    sample();
    check1("rst_inst_valid", inst_valid, 1'b0);
    check1("rst_inst_err", inst_err, 1'b0);
    check1("rst_inst_busy", inst_busy, 1'b0);
    check1("rst_arvalid", axi.arvalid, 1'b0);
    check1("rst_rready", axi.rready, 1'b0);
    check32("rst_araddr", axi.araddr, 32'h0);
    check32("rst_inst_data", inst_data, 32'h0);
    check32("arlen_const", {24'h0, axi.arlen}, 32'h0);
    check32("arsize_burst_id", {23'h0, axi.arsize, axi.arburst, axi.arid}, {23'h0, 3'b010, 2'b01, 4'h0});
    cyc();
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) runVector(vecs[i], 0);

    // Flush while the address is still waiting for arready.
    rises0 = validRises;
    cyc();
    arWait = 4;
    rWait  = 1;
    slvData = 32'hdeadbeef;
    slvResp = 2'b00;
    fetch_en   = 1'b1;
    fetch_addr = 32'hbfc00100;
    cyc();
    fetch_en = 1'b0;
    sample();
    check1("ar_flush_arvalid_n1", axi.arvalid, 1'b1);
    cyc();
    flush = 1'b1;
    sample();
    check1("ar_flush_arvalid", axi.arvalid, 1'b1);
    check1("ar_flush_arready_low", axi.arready, 1'b0);
    check32("ar_flush_araddr", axi.araddr, 32'hbfc00100);
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 20) begin
      cyc();
      flush = 1'b0;
      sample();
      check1("ar_flush_arvalid_hold", axi.arvalid, 1'b1);
      hs = axi.arready;
      n++;
    end
    check1("ar_flush_handshake", hs, 1'b1);
    n = 0;
    do begin
      cyc();
      sample();
      check1("ar_flush_novalid", inst_valid, 1'b0);
      check1("ar_flush_no_reissue", axi.arvalid, 1'b0);
      n++;
    end while (inst_busy && n < 20);
    check1("ar_flush_idle", inst_busy, 1'b0);
    check1("ar_flush_beat_taken", axi.rvalid, 1'b0);
    check32("ar_flush_rises", 32'(validRises), 32'(rises0));
    v = '{32'hbfc00380, 32'h8c080000, 2'b00, 0, 0, 3, 1'b0, 0, 1'b0};
    runVector(v, 0);

    // Flush in R: coincident with the beat, then ahead of a delayed beat.
    for (int k = 0; k < 2; k++) begin
      rises0 = validRises;
      cyc();
      arWait = 0;
      rWait  = (k == 0) ? 0 : 3;
      slvData = 32'h0badf00d;
      slvResp = 2'b00;
      fetch_en   = 1'b1;
      fetch_addr = 32'hbfc00200;
      cyc();
      fetch_en = 1'b0;
      cyc();
      if (k != 0) cyc();
      flush = 1'b1;
      sample();
      check1("r_flush_rready", axi.rready, 1'b1);
      check1("r_flush_rvalid", axi.rvalid, (k == 0));
      n = 0;
      do begin
        cyc();
        flush = 1'b0;
        sample();
        check1("r_flush_novalid", inst_valid, 1'b0);
        n++;
      end while (inst_busy && n < 20);
      check1("r_flush_idle", inst_busy, 1'b0);
      check1("r_flush_beat_taken", axi.rvalid, 1'b0);
      check32("r_flush_rises", 32'(validRises), 32'(rises0));
    end

    v = '{32'hbfc00600, 32'h12345678, 2'b00, 0, 0, 3, 1'b0, 1, 1'b0};
    runVector(v, 1);
    v = '{32'hbfc00400, 32'h11110000, 2'b00, 1, 1, 5, 1'b0, 0, 1'b0};
    runVector(v, 2);

    // Asynchronous reset in the middle of a read.
    cyc();
    arWait = 0;
    rWait  = 6;
    slvData = 32'h77777777;
    slvResp = 2'b00;
    fetch_en   = 1'b1;
    fetch_addr = 32'hbfc00500;
    cyc();
    fetch_en = 1'b0;
    cyc();
    cyc();
    check1("rst_mid_in_r", axi.rready, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check1("rst_mid_rready", axi.rready, 1'b0);
    check1("rst_mid_arvalid", axi.arvalid, 1'b0);
    check1("rst_mid_inst_valid", inst_valid, 1'b0);
    check1("rst_mid_busy", inst_busy, 1'b0);
    check32("rst_mid_inst_data", inst_data, 32'h0);
    cyc();
    cyc();
    resetn = 1'b1;
    v = '{32'hbfc00700, 32'h00430821, 2'b00, 1, 2, 6, 1'b0, 1, 1'b0};
    runVector(v, 0);

    check32("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
